// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM states and operand routing for the ALU sequencer.
package alu_seq_pkg;

  localparam logic [3:0] OP_MOV  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_NOT  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_J    = 4'h8;
  localparam logic [3:0] OP_JAL  = 4'h9;
  localparam logic [3:0] OP_LW   = 4'hA;
  localparam logic [3:0] OP_SW   = 4'hB;
  localparam logic [3:0] OP_BEQ  = 4'hC;
  localparam logic [3:0] OP_BNE  = 4'hD;
  localparam logic [3:0] OP_ADDI = 4'hE;
  localparam logic [3:0] OP_LI   = 4'hF;

  localparam logic [7:0] BUBBLE_INSTR = 8'hA0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    TRAP
  } state_t;

  typedef struct packed {
    logic [7:0] in0;
    logic [7:0] in1;
  } operands_t;

  // Unary ops see R[rt] on both inputs; immediates come from the rt field.
  function automatic operands_t route_operands(input logic [7:0] instr,
                                               input logic [7:0] rs_val,
                                               input logic [7:0] rt_val);
    operands_t o;
    o.in0 = rs_val;
    o.in1 = rt_val;
    case (instr[7:4])
      OP_MOV, OP_NOT, OP_SHL, OP_SHR: begin
        o.in0 = rt_val;
        o.in1 = rt_val;
      end
      OP_ADDI: o.in1 = {6'b0, instr[1:0]};
      OP_LI: begin
        o.in0 = {6'b0, instr[1:0]};
        o.in1 = 8'h00;
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// 4x8 register file: two asynchronous read ports, one synchronous write port.
// Reads see the pre-write value in the write cycle; cleared by async reset.
module alu_seq_regfile (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [7:0] wdata,
  input  logic [1:0] raddr_a,
  output logic [7:0] rdata_a,
  input  logic [1:0] raddr_b,
  output logic [7:0] rdata_b
);

  logic [3:0][7:0] regs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/writeback sequencer for the 8-bit ALU; ALU op 4 cycles, LW/SW 5 minimum.
// Stalls in FETCH/MEM until ack; OVF_TRAP_EN makes an overflowing ADD park in TRAP.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter logic [7:0] PC_RESET = 8'h00,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             imem_req,
  output logic [7:0]       imem_addr,
  input  logic             imem_ack,
  input  logic [7:0]       imem_rdata,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [7:0]       dmem_addr,
  output logic [7:0]       dmem_wdata,
  input  logic             dmem_ack,
  input  logic [7:0]       dmem_rdata,
  output logic [7:0]       alu_instr,
  output logic [7:0]       alu_in0,
  output logic [7:0]       alu_in1,
  input  logic [7:0]       alu_out,
  input  logic [7:0]       alu_jump,
  input  logic             alu_ovf,
  output logic [7:0]       pc,
  output logic             halted,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] retired
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [7:0]       pc_q, pc_d;
  logic [7:0]       ir_q, ir_d;
  logic             imem_req_q, imem_req_d;
  logic             dmem_req_q, dmem_req_d;
  logic             dmem_we_q, dmem_we_d;
  logic [7:0]       dmem_addr_q, dmem_addr_d;
  logic [7:0]       dmem_wdata_q, dmem_wdata_d;
  logic [7:0]       alu_instr_q, alu_instr_d;
  logic [7:0]       alu_in0_q, alu_in0_d;
  logic [7:0]       alu_in1_q, alu_in1_d;
  logic [7:0]       res_q, res_d;
  logic             jmp_q, jmp_d;
  logic             ovf_sticky_q, ovf_sticky_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [3:0]       op;
  logic [1:0]       rs_sel, rt_sel;
  logic [7:0]       rd_a, rd_b;
  logic             rf_we;
  logic [1:0]       rf_waddr;
  logic [7:0]       rf_wdata;
  logic [7:0]       pc_inc;
  operands_t        ops;

  assign op     = ir_q[7:4];
  assign pc_inc = pc_q + 8'd1;

  // During FETCH the ports are addressed straight from the returning instruction
  // so operands can be registered on the ack edge; branches read R0 in WB.
  always_comb begin
    rs_sel = ir_q[3:2];
    rt_sel = ir_q[1:0];
    if (state_q == FETCH) begin
      rs_sel = imem_rdata[3:2];
      rt_sel = imem_rdata[1:0];
    end else if (state_q == WB && (op == OP_BEQ || op == OP_BNE)) begin
      rt_sel = 2'd0;
    end
  end

  assign ops = route_operands(imem_rdata, rd_a, rd_b);

  alu_seq_regfile u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (rs_sel),
    .rdata_a (rd_a),
    .raddr_b (rt_sel),
    .rdata_b (rd_b)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    imem_req_d   = imem_req_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    alu_instr_d  = alu_instr_q;
    alu_in0_d    = alu_in0_q;
    alu_in1_d    = alu_in1_q;
    res_d        = res_q;
    jmp_d        = jmp_q;
    ovf_sticky_d = ovf_sticky_q;
    retired_d    = retired_q;
    rf_we        = 1'b0;
    rf_waddr     = ir_q[3:2];
    rf_wdata     = res_q;

    case (state_q)
      IDLE: begin
        if (run) begin
          state_d    = FETCH;
          imem_req_d = 1'b1;
        end
      end
      FETCH: begin
        if (imem_req_q && imem_ack) begin
          state_d    = DECODE;
          imem_req_d = 1'b0;
          ir_d       = imem_rdata;
          alu_in0_d  = ops.in0;
          alu_in1_d  = ops.in1;
        end
      end
      DECODE: begin
        alu_instr_d = ir_q;
        state_d     = EXEC;
      end
      EXEC: begin
        alu_instr_d = BUBBLE_INSTR;
        res_d       = alu_out;
        jmp_d       = (alu_jump != 8'h00);
        if (op == OP_ADD && alu_ovf) begin
          ovf_sticky_d = 1'b1;
        end
        if (op == OP_LW || op == OP_SW) begin
          state_d      = MEM;
          dmem_req_d   = 1'b1;
          dmem_we_d    = (op == OP_SW);
          dmem_addr_d  = rd_b;
          dmem_wdata_d = rd_a;
        end else begin
          state_d = WB;
        end
`ifdef OVF_TRAP_EN
        if (op == OP_ADD && alu_ovf) begin
          state_d = TRAP;
        end
`endif
      end
      MEM: begin
        if (dmem_req_q && dmem_ack) begin
          state_d    = WB;
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          res_d      = dmem_rdata;
        end
      end
      WB: begin
        retired_d = retired_q + CNT_ONE;
        pc_d      = pc_inc;
        case (op)
          OP_J: begin
            if (jmp_q) pc_d = rd_a;
          end
          OP_JAL: begin
            if (jmp_q) pc_d = rd_a;
            rf_we    = 1'b1;
            rf_waddr = 2'd3;
            rf_wdata = pc_inc;
          end
          OP_BEQ, OP_BNE: begin
            if (jmp_q) pc_d = rd_b;
          end
          OP_SW: ;
          default: rf_we = 1'b1;
        endcase
        if (run) begin
          state_d    = FETCH;
          imem_req_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      TRAP: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= PC_RESET;
      ir_q         <= 8'h00;
      imem_req_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 8'h00;
      dmem_wdata_q <= 8'h00;
      alu_instr_q  <= BUBBLE_INSTR;
      alu_in0_q    <= 8'h00;
      alu_in1_q    <= 8'h00;
      res_q        <= 8'h00;
      jmp_q        <= 1'b0;
      ovf_sticky_q <= 1'b0;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      imem_req_q   <= imem_req_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      alu_instr_q  <= alu_instr_d;
      alu_in0_q    <= alu_in0_d;
      alu_in1_q    <= alu_in1_d;
      res_q        <= res_d;
      jmp_q        <= jmp_d;
      ovf_sticky_q <= ovf_sticky_d;
      retired_q    <= retired_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign alu_instr  = alu_instr_q;
  assign alu_in0    = alu_in0_q;
  assign alu_in1    = alu_in1_q;
  assign pc         = pc_q;
  assign halted     = (state_q == IDLE) || (state_q == TRAP);
  assign ovf_sticky = ovf_sticky_q;
  assign retired    = retired_q;

endmodule
